// File: rtl/cbm2_segmap.sv
`default_nettype none
// ============================================================================
// Module   : cbm2_segmap
// Brief    : 6509 segment unit; execution/indirection registers at $0000/$0001
//            and (zp),Y data-cycle redirection to the indirection segment.
// Revision : 1.0
// ============================================================================
module cbm2_segmap #(
    parameter logic [3:0] RESET_SEG = 4'hF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cpuEn,
    input  logic        cpuSync,
    input  logic [15:0] cpuAddr,
    input  logic        cpuWe,
    input  logic [7:0]  cpuDo,
    input  logic [7:0]  cpuDi,
    output logic [7:0]  cpuSeg,
    output logic        regHit,
    output logic [7:0]  regData,
    output logic [3:0]  execSeg,
    output logic [3:0]  indSeg
);

    localparam logic [2:0] c_CYC_MAX   = 3'd7;
    localparam logic [2:0] c_CYC_IND   = 3'd4;
    localparam logic [7:0] c_OP_LDA_IY = 8'hB1;
    localparam logic [7:0] c_OP_STA_IY = 8'h91;

    logic [3:0] r_exec;
    logic [3:0] r_ind;
    logic       r_ind_op;
    logic [2:0] r_cyc;

    logic       w_reg_addr;
    logic       w_use_ind;
    logic       w_unused;

    assign w_reg_addr = (cpuAddr[15:1] == 15'd0);
    assign w_unused   = ^cpuDo[7:4];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_exec   <= RESET_SEG;
            r_ind    <= RESET_SEG;
            r_ind_op <= 1'b0;
            r_cyc    <= 3'd0;
        end else if (cpuEn) begin
            // Register writes still reach memory; only the low nibble is kept.
            if (cpuWe && w_reg_addr) begin
                if (cpuAddr[0])
                    r_ind  <= cpuDo[3:0];
                else
                    r_exec <= cpuDo[3:0];
            end
            if (cpuSync) begin
                r_ind_op <= (cpuDi == c_OP_LDA_IY) || (cpuDi == c_OP_STA_IY);
                r_cyc    <= 3'd1;
            end else if (r_cyc != c_CYC_MAX) begin
                r_cyc    <= r_cyc + 3'd1;
            end
        end
    end

    // Sync cycles always fetch from the execution segment.
    assign w_use_ind = r_ind_op && !cpuSync && (r_cyc >= c_CYC_IND);

    assign cpuSeg  = {4'h0, w_use_ind ? r_ind : r_exec};
    assign regHit  = !cpuWe && w_reg_addr;
    assign regData = {4'h0, cpuAddr[0] ? r_ind : r_exec};
    assign execSeg = r_exec;
    assign indSeg  = r_ind;

endmodule
`default_nettype wire

// File: tb/tb_cbm2_segmap.sv
`default_nettype none
// ============================================================================
// Module   : tb_cbm2_segmap
// Brief    : Directed self-checking bench for cbm2_segmap.
// Revision : 1.0
// ============================================================================
module tb_cbm2_segmap;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cpuEn;
    logic        cpuSync;
    logic [15:0] cpuAddr;
    logic        cpuWe;
    logic [7:0]  cpuDo;
    logic [7:0]  cpuDi;
    logic [7:0]  cpuSeg;
    logic        regHit;
    logic [7:0]  regData;
    logic [3:0]  execSeg;
    logic [3:0]  indSeg;

    int n_cmp = 0;
    int n_bad = 0;

    cbm2_segmap #(.RESET_SEG(4'hF)) u_dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .cpuEn   (cpuEn),
        .cpuSync (cpuSync),
        .cpuAddr (cpuAddr),
        .cpuWe   (cpuWe),
        .cpuDo   (cpuDo),
        .cpuDi   (cpuDi),
        .cpuSeg  (cpuSeg),
        .regHit  (regHit),
        .regData (regData),
        .execSeg (execSeg),
        .indSeg  (indSeg)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic sync, input logic [15:0] addr,
                         input logic we, input logic [7:0] dout, input logic [7:0] din);
        cpuEn   = en;
        cpuSync = sync;
        cpuAddr = addr;
        cpuWe   = we;
        cpuDo   = dout;
        cpuDi   = din;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One CPU bus cycle: present inputs, check the segment, then end the cycle.
    task automatic bus(input string tag, input logic sync, input logic [15:0] addr,
                       input logic we, input logic [7:0] dout, input logic [7:0] din,
                       input logic [7:0] exp_seg);
        drive(1'b1, sync, addr, we, dout, din);
        check(tag, cpuSeg, exp_seg);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        check("rst_seg",    cpuSeg, 8'h0F);
        check("rst_exec",   {4'h0, execSeg}, 8'h0F);
        check("rst_ind",    {4'h0, indSeg}, 8'h0F);
        check("rst_hit",    {7'd0, regHit}, 8'h01);
        check("rst_rdata0", regData, 8'h0F);
        reset = 1'b0;

        // exec write: new value only from the following cycle
        bus("wr0_seg", 1'b0, 16'h0000, 1'b1, 8'hA3, 8'h00, 8'h0F);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00);
        check("rd0_seg",   cpuSeg, 8'h03);
        check("rd0_hit",   {7'd0, regHit}, 8'h01);
        check("rd0_data",  regData, 8'h03);
        check("rd0_exec",  {4'h0, execSeg}, 8'h03);
        tick();
        drive(1'b1, 1'b0, 16'h0002, 1'b0, 8'h00, 8'h00);
        check("rd2_nohit", {7'd0, regHit}, 8'h00);
        tick();

        bus("wr0_F", 1'b0, 16'h0000, 1'b1, 8'h5F, 8'h00, 8'h03);
        bus("wr1_1", 1'b0, 16'h0001, 1'b1, 8'h01, 8'h00, 8'h0F);
        drive(1'b1, 1'b0, 16'h0001, 1'b0, 8'h00, 8'h00);
        check("rd1_data", regData, 8'h01);
        tick();

        // LDA (zp),Y with an idle non-enabled clock in the middle
        bus("b1_c0", 1'b1, 16'h2000, 1'b0, 8'h00, 8'hB1, 8'h0F);
        bus("b1_c1", 1'b0, 16'h2001, 1'b0, 8'h00, 8'h40, 8'h0F);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00);
        check("idle_seg", cpuSeg, 8'h0F);
        tick();
        check("idle_exec", {4'h0, execSeg}, 8'h0F);
        bus("b1_c2", 1'b0, 16'h0040, 1'b0, 8'h00, 8'h00, 8'h0F);
        bus("b1_c3", 1'b0, 16'h0041, 1'b0, 8'h00, 8'h30, 8'h0F);
        bus("b1_c4", 1'b0, 16'h3000, 1'b0, 8'h00, 8'h77, 8'h01);
        bus("b1_nx", 1'b1, 16'h2002, 1'b0, 8'h00, 8'hEA, 8'h0F);

        // STA (zp),Y whose write cycle hits $0001
        bus("wr1_2",  1'b0, 16'h0001, 1'b1, 8'h02, 8'h00, 8'h0F);
        bus("91_c0",  1'b1, 16'h2003, 1'b0, 8'h00, 8'h91, 8'h0F);
        bus("91_c1",  1'b0, 16'h2004, 1'b0, 8'h00, 8'h50, 8'h0F);
        bus("91_c2",  1'b0, 16'h0050, 1'b0, 8'h00, 8'hFF, 8'h0F);
        bus("91_c3",  1'b0, 16'h0051, 1'b0, 8'h00, 8'hFF, 8'h0F);
        bus("91_c4",  1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'h02);
        drive(1'b1, 1'b0, 16'h0001, 1'b1, 8'h05, 8'h00);
        check("91_c5_seg", cpuSeg, 8'h02);
        check("91_c5_hit", {7'd0, regHit}, 8'h00);
        tick();
        bus("91_c6",  1'b0, 16'h2005, 1'b0, 8'h00, 8'h00, 8'h05);
        bus("91_c7",  1'b0, 16'h2005, 1'b0, 8'h00, 8'h00, 8'h05);
        bus("91_c8",  1'b0, 16'h2005, 1'b0, 8'h00, 8'h00, 8'h05);
        bus("91_c9",  1'b0, 16'h2005, 1'b0, 8'h00, 8'h00, 8'h05);
        bus("91_nx",  1'b1, 16'h2005, 1'b0, 8'h00, 8'hA9, 8'h0F);

        // LDA # then LDA zp,X never leave exec
        bus("a9_c1", 1'b0, 16'h2006, 1'b0, 8'h00, 8'h12, 8'h0F);
        bus("b5_c0", 1'b1, 16'h2007, 1'b0, 8'h00, 8'hB5, 8'h0F);
        for (int i = 1; i <= 4; i++)
            bus($sformatf("b5_c%0d", i), 1'b0, 16'h0060, 1'b0, 8'h00, 8'h00, 8'h0F);

        // Reset during cycle 4 of LDA (zp),Y
        bus("rb_c0", 1'b1, 16'h2008, 1'b0, 8'h00, 8'hB1, 8'h0F);
        bus("rb_c1", 1'b0, 16'h2009, 1'b0, 8'h00, 8'h70, 8'h0F);
        bus("rb_c2", 1'b0, 16'h0070, 1'b0, 8'h00, 8'h00, 8'h0F);
        bus("rb_c3", 1'b0, 16'h0071, 1'b0, 8'h00, 8'h40, 8'h0F);
        drive(1'b1, 1'b0, 16'h4000, 1'b0, 8'h00, 8'h00);
        check("rb_c4", cpuSeg, 8'h05);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 16'h0001, 1'b0, 8'h00, 8'h00);
        check("rb_seg",   cpuSeg, 8'h0F);
        check("rb_ind",   {4'h0, indSeg}, 8'h0F);
        check("rb_rdata", regData, 8'h0F);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
